// File: rtl/qtcore_control_unit_v2.sv
// qtcore_control_unit_v2: multi-cycle control FSM for the qtcore accumulator
// CPU with a mem_req/mem_ready handshake, a wait-state watchdog that raises a
// sticky bus error, and a scan chain over {bus_error, wait counter, state}.
module qtcore_control_unit_v2 #(
  parameter int          MEM_TIMEOUT = 15,
  parameter int          CNT_W       = 4,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       processor_enable,
  input  logic [7:0] instruction,
  input  logic       ZF,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PC_write_enable,
  output logic [1:0] PC_mux_select,
  output logic       ACC_write_enable,
  output logic [1:0] ACC_mux_select,
  output logic       IR_load_enable,
  output logic       ALU_inputB_mux_select,
  output logic       Memory_write_enable,
  output logic [1:0] Memory_address_mux_select,
  output logic       processor_halted,
  output logic       bus_error,
  input  logic       scan_enable,
  input  logic       scan_in,
  output logic       scan_out
);

  typedef enum logic [2:0] {
    S_RESET   = 3'b000,
    S_FETCH   = 3'b001,
    S_EXECUTE = 3'b010,
    S_HALT    = 3'b100
  } state_t;

  localparam int CHAIN_W = 3 + CNT_W + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               bus_error_nxt;
  logic               timeout_hit;
  logic               mem_op, store_op;
  logic [CHAIN_W-1:0] chain, chain_shift;

  // Scan order: scan_in -> state[0..2] -> cnt[0..CNT_W-1] -> bus_error -> scan_out
  assign chain       = {bus_error, cnt, state};
  assign chain_shift = {chain[CHAIN_W-2:0], scan_in};
  assign scan_out    = bus_error;

  // Watchdog fires only on a still-pending access; a ready in the same cycle wins
  assign timeout_hit = (MEM_TIMEOUT > 0) && (cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  // The B-operand select follows the IR directly; only RESET forces it low
  assign ALU_inputB_mux_select = (state != S_RESET) && (instruction[7:4] == 4'b1110);
  assign processor_halted      = (state == S_HALT);

  // Next-state and strobe decode; strobes are silenced when disabled or scanning
  always_comb begin
    state_nxt                 = state;
    mem_req                   = 1'b0;
    PC_write_enable           = 1'b0;
    PC_mux_select             = 2'b00;
    ACC_write_enable          = 1'b0;
    ACC_mux_select            = 2'b00;
    IR_load_enable            = 1'b0;
    Memory_write_enable       = 1'b0;
    Memory_address_mux_select = 2'b00;
    mem_op                    = 1'b0;
    store_op                  = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req                   = 1'b1;
        Memory_address_mux_select = 2'b10;
        if (mem_ready) begin
          IR_load_enable  = 1'b1;
          PC_write_enable = 1'b1;
          state_nxt       = S_EXECUTE;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_EXECUTE: begin
        state_nxt = S_FETCH;
        if (instruction == HALT_OPCODE) begin
          state_nxt = S_HALT;
        end else begin
          casez (instruction)
            8'b000?????: begin mem_op = 1'b1; ACC_mux_select = 2'b01; end
            8'b001?????: begin mem_op = 1'b1; store_op = 1'b1; end
            8'b010?????, 8'b011?????, 8'b100?????,
            8'b101?????, 8'b110?????: mem_op = 1'b1;
            8'b1110????, 8'b11110???: ACC_write_enable = 1'b1;
            8'hF8: begin PC_write_enable = ZF;  PC_mux_select = 2'b11; end
            8'hFA: begin PC_write_enable = !ZF; PC_mux_select = 2'b11; end
            8'hF9: begin PC_write_enable = ZF;  PC_mux_select = 2'b10; end
            8'hFB: begin PC_write_enable = !ZF; PC_mux_select = 2'b10; end
            8'hFC: begin
              mem_op                    = 1'b1;
              ACC_mux_select            = 2'b01;
              Memory_address_mux_select = 2'b01;
            end
            8'hFD: begin
              ACC_write_enable = 1'b1;
              ACC_mux_select   = 2'b10;
              PC_write_enable  = 1'b1;
              PC_mux_select    = 2'b01;
            end
            8'hFE: begin PC_write_enable = 1'b1; PC_mux_select = 2'b01; end
            default: ;
          endcase
          if (mem_op) begin
            mem_req             = 1'b1;
            Memory_write_enable = store_op;
            if (mem_ready) begin
              ACC_write_enable = !store_op;
              state_nxt        = S_FETCH;
            end else if (timeout_hit) begin
              state_nxt = S_HALT;
            end else begin
              state_nxt = S_EXECUTE;
            end
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    if (!processor_enable || scan_enable) begin
      mem_req                   = 1'b0;
      PC_write_enable           = 1'b0;
      PC_mux_select             = 2'b00;
      ACC_write_enable          = 1'b0;
      ACC_mux_select            = 2'b00;
      IR_load_enable            = 1'b0;
      Memory_write_enable       = 1'b0;
      Memory_address_mux_select = 2'b00;
    end
  end

  // Wait counter clears on completion or state change and saturates otherwise
  always_comb begin
    cnt_nxt       = cnt;
    bus_error_nxt = bus_error | (mem_req & timeout_hit);
    if ((state_nxt != state) || mem_ready)
      cnt_nxt = '0;
    else if (mem_req && (cnt != {CNT_W{1'b1}}))
      cnt_nxt = cnt + 1'b1;
  end

  // State, counter and error register; scan shift overrides functional update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RESET;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else if (scan_enable) begin
      state     <= state_t'(chain_shift[2:0]);
      cnt       <= chain_shift[CNT_W+2:3];
      bus_error <= chain_shift[CHAIN_W-1];
    end else if (processor_enable) begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bus_error <= bus_error_nxt;
    end
  end

endmodule

// File: tb/tb_qtcore_control_unit_v2.sv
// Directed testbench for qtcore_control_unit_v2 (MEM_TIMEOUT=4, CNT_W=4).
module tb_qtcore_control_unit_v2;
  logic       clk = 1'b0, rst = 1'b0, processor_enable = 1'b0, ZF = 1'b0;
  logic       mem_ready = 1'b0, scan_enable = 1'b0, scan_in = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       mem_req, PC_write_enable, ACC_write_enable, IR_load_enable;
  logic       ALU_inputB_mux_select, Memory_write_enable, processor_halted;
  logic       bus_error, scan_out;
  logic [1:0] PC_mux_select, ACC_mux_select, Memory_address_mux_select;
  logic [13:0] obs;
  int errs = 0, checks = 0;

  qtcore_control_unit_v2 #(.MEM_TIMEOUT(4), .CNT_W(4), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .processor_enable(processor_enable),
    .instruction(instruction), .ZF(ZF), .mem_ready(mem_ready), .mem_req(mem_req),
    .PC_write_enable(PC_write_enable), .PC_mux_select(PC_mux_select),
    .ACC_write_enable(ACC_write_enable), .ACC_mux_select(ACC_mux_select),
    .IR_load_enable(IR_load_enable), .ALU_inputB_mux_select(ALU_inputB_mux_select),
    .Memory_write_enable(Memory_write_enable),
    .Memory_address_mux_select(Memory_address_mux_select),
    .processor_halted(processor_halted), .bus_error(bus_error),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, PC_write_enable, PC_mux_select, ACC_write_enable, ACC_mux_select,
                IR_load_enable, ALU_inputB_mux_select, Memory_write_enable,
                Memory_address_mux_select, processor_halted, bus_error};

  // Expected-output vector builder, same field order as obs
  function automatic logic [13:0] o(input logic mrq, input logic pcwe, input logic [1:0] pcs,
                                    input logic accwe, input logic [1:0] accs, input logic ir,
                                    input logic alub, input logic mwe, input logic [1:0] adr,
                                    input logic hlt, input logic be);
    return {mrq, pcwe, pcs, accwe, accs, ir, alub, mwe, adr, hlt, be};
  endfunction

  localparam logic [13:0] ZERO     = 14'b0;
  localparam logic [13:0] FETCH_OK = 14'b1_1_00_0_00_1_0_0_10_0_0;
  localparam logic [13:0] FETCH_WT = 14'b1_0_00_0_00_0_0_0_10_0_0;
  localparam logic [13:0] HALT_BE  = 14'b0_0_00_0_00_0_0_0_00_1_1;
  localparam logic [13:0] HALT_OK  = 14'b0_0_00_0_00_0_0_0_00_1_0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; processor_enable = 1'b1; scan_enable = 1'b0; mem_ready = 1'b1; ZF = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Reset, then fetch the given instruction so the DUT sits in EXECUTE
  task automatic enter_exec(input logic [7:0] ins, input logic zf);
    do_reset(); instruction = ins; ZF = zf; mem_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; processor_enable = 1'b1; mem_ready = 1'b1; instruction = 8'h05; #1;
    checks++; if (obs !== ZERO) begin errs++; $display("FAIL reset_asserted: got %b want %b", obs, ZERO); end
    tick(); rst = 1'b1; #1;
    checks++; if (obs !== ZERO) begin errs++; $display("FAIL reset_state: got %b want %b", obs, ZERO); end
  endtask

  task automatic test_lda();
    logic [13:0] ex;
    do_reset(); instruction = 8'h05; #1;
    checks++; if (obs !== ZERO) begin errs++; $display("FAIL lda_reset: got %b want %b", obs, ZERO); end
    tick();
    checks++; if (obs !== FETCH_OK) begin errs++; $display("FAIL lda_fetch: got %b want %b", obs, FETCH_OK); end
    tick(); ex = o(1,0,2'b00,1,2'b01,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL lda_exec: got %b want %b", obs, ex); end
    tick();
    checks++; if (obs !== FETCH_OK) begin errs++; $display("FAIL lda_refetch: got %b want %b", obs, FETCH_OK); end
  endtask

  task automatic test_sta_wait();
    logic [13:0] ex;
    enter_exec(8'h23, 1'b0); mem_ready = 1'b0;
    ex = o(1,0,2'b00,0,2'b00,0,0,1,2'b00,0,0);
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== ex) begin errs++; $display("FAIL sta_wait%0d: got %b want %b", i, obs, ex); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (obs !== ex) begin errs++; $display("FAIL sta_ready: got %b want %b", obs, ex); end
    tick();
    checks++; if (obs !== FETCH_OK) begin errs++; $display("FAIL sta_fetch: got %b want %b", obs, FETCH_OK); end
  endtask

  task automatic test_timeout();
    logic [13:0] ex;
    do_reset(); instruction = 8'h05; tick(); mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== FETCH_WT) begin errs++; $display("FAIL to_wait%0d: got %b want %b", i, obs, FETCH_WT); end
      tick();
    end
    checks++; if (obs !== HALT_BE) begin errs++; $display("FAIL to_halt: got %b want %b", obs, HALT_BE); end
    mem_ready = 1'b1; tick(); tick();
    checks++; if (obs !== HALT_BE) begin errs++; $display("FAIL to_sticky: got %b want %b", obs, HALT_BE); end
    rst = 1'b0; #1;
    checks++; if (obs !== ZERO) begin errs++; $display("FAIL to_clear: got %b want %b", obs, ZERO); end
    // Ready arriving in the cycle the counter reaches the limit completes the fetch
    do_reset(); instruction = 8'h05; tick(); mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b1; #1;
    checks++; if (obs !== FETCH_OK) begin errs++; $display("FAIL to_edge_fetch: got %b want %b", obs, FETCH_OK); end
    tick(); ex = o(1,0,2'b00,1,2'b01,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL to_edge_exec: got %b want %b", obs, ex); end
  endtask

  task automatic test_branch();
    logic [13:0] ex;
    enter_exec(8'hF8, 1'b1); ex = o(0,1,2'b11,0,2'b00,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL beqf_taken: got %b want %b", obs, ex); end
    enter_exec(8'hF8, 1'b0); ex = o(0,0,2'b11,0,2'b00,0,0,0,2'b00,0,0);
    checks++; if (obs[12] !== 1'b0) begin errs++; $display("FAIL beqf_not_taken: got %b want %b", obs, ex); end
    tick();
    checks++; if (obs !== FETCH_OK) begin errs++; $display("FAIL beqf_fetch: got %b want %b", obs, FETCH_OK); end
    enter_exec(8'hFB, 1'b0); ex = o(0,1,2'b10,0,2'b00,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL bneb_taken: got %b want %b", obs, ex); end
    enter_exec(8'hFA, 1'b1);
    checks++; if (obs[12] !== 1'b0) begin errs++; $display("FAIL bnef_not_taken: got %b want 0", obs[12]); end
  endtask

  task automatic test_single_cycle();
    logic [13:0] ex;
    enter_exec(8'hFD, 1'b0); ex = o(0,1,2'b01,1,2'b10,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL jsr: got %b want %b", obs, ex); end
    enter_exec(8'hFE, 1'b0); ex = o(0,1,2'b01,0,2'b00,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL jmp: got %b want %b", obs, ex); end
    enter_exec(8'hE3, 1'b0); ex = o(0,0,2'b00,1,2'b00,0,1,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL addi: got %b want %b", obs, ex); end
    enter_exec(8'hF3, 1'b0); ex = o(0,0,2'b00,1,2'b00,0,0,0,2'b00,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL unary: got %b want %b", obs, ex); end
    enter_exec(8'hFC, 1'b0); ex = o(1,0,2'b00,1,2'b01,0,0,0,2'b01,0,0);
    checks++; if (obs !== ex) begin errs++; $display("FAIL ldar: got %b want %b", obs, ex); end
  endtask

  task automatic test_halt();
    enter_exec(8'hFF, 1'b0);
    checks++; if (obs !== ZERO) begin errs++; $display("FAIL halt_exec: got %b want %b", obs, ZERO); end
    tick(); tick(); tick();
    checks++; if (obs !== HALT_OK) begin errs++; $display("FAIL halt_stay: got %b want %b", obs, HALT_OK); end
  endtask

  task automatic test_enable();
    do_reset(); instruction = 8'h05; tick(); mem_ready = 1'b0; tick(); tick();
    processor_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== ZERO) begin errs++; $display("FAIL en_off%0d: got %b want %b", i, obs, ZERO); end
      tick();
    end
    processor_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== FETCH_WT) begin errs++; $display("FAIL en_resume%0d: got %b want %b", i, obs, FETCH_WT); end
      tick();
    end
    checks++; if (obs !== HALT_BE) begin errs++; $display("FAIL en_timeout: got %b want %b", obs, HALT_BE); end
  endtask

  task automatic test_scan();
    logic [7:0] pat, got, got2;
    pat = 8'b1011_0010; got = '0; got2 = '0;
    do_reset(); instruction = 8'h05; tick(); mem_ready = 1'b0; tick(); tick();
    scan_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      scan_in = pat[7-k]; #1;
      checks++;
      if (obs[13:2] !== 12'b0) begin errs++; $display("FAIL scan_strobes%0d: got %b want 0", k, obs[13:2]); end
      got = {got[6:0], scan_out};
      tick();
    end
    checks++; if (got !== 8'b0001_0001) begin errs++; $display("FAIL scan_capture: got %b want %b", got, 8'b0001_0001); end
    for (int k = 0; k < 8; k++) begin
      scan_in = got[7-k]; #1;
      got2 = {got2[6:0], scan_out};
      tick();
    end
    checks++; if (got2 !== pat) begin errs++; $display("FAIL scan_pattern: got %b want %b", got2, pat); end
    scan_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== FETCH_WT) begin errs++; $display("FAIL scan_resume%0d: got %b want %b", i, obs, FETCH_WT); end
      tick();
    end
    checks++; if (obs !== HALT_BE) begin errs++; $display("FAIL scan_timeout: got %b want %b", obs, HALT_BE); end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sta_wait();
    test_timeout();
    test_branch();
    test_single_cycle();
    test_halt();
    test_enable();
    test_scan();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
